// File: rtl/mult_pkg.sv
// Shared definitions for the sequential Booth multiplier.
//
// Contents:
//   OP_MUL / OP_MULH / OP_MULHSU / OP_MULHU  RV32M multiply op encodings
//   state_t   sequencer states (IDLE, CALC, DONE)
//   digit_t   radix-4 Booth digit selects (ZERO, POS1, POS2, NEG1, NEG2)
//   booth_digit()               3-bit window -> digit select
//   a_is_signed() / b_is_signed()  operand signedness for a given op
package mult_pkg;

    localparam logic [1:0] OP_MUL    = 2'b00;
    localparam logic [1:0] OP_MULH   = 2'b01;
    localparam logic [1:0] OP_MULHSU = 2'b10;
    localparam logic [1:0] OP_MULHU  = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    typedef enum logic [2:0] {
        ZERO = 3'd0,
        POS1 = 3'd1,
        POS2 = 3'd2,
        NEG1 = 3'd3,
        NEG2 = 3'd4
    } digit_t;

    // Window is {b[2i+1], b[2i], b[2i-1]}.
    function automatic digit_t booth_digit(input logic [2:0] window);
        digit_t d;
        case (window)
            3'b001, 3'b010: d = POS1;
            3'b011:         d = POS2;
            3'b100:         d = NEG2;
            3'b101, 3'b110: d = NEG1;
            default:        d = ZERO;   // 000 and 111
        endcase
        return d;
    endfunction

    // Multiplicand is unsigned only for MULHU.
    function automatic logic a_is_signed(input logic [1:0] op);
        return (op != OP_MULHU);
    endfunction

    // Multiplier is signed only for MUL and MULH.
    function automatic logic b_is_signed(input logic [1:0] op);
        return (op == OP_MUL) || (op == OP_MULH);
    endfunction

endpackage

// File: rtl/booth_digit_enc.sv
// Radix-4 Booth digit encoder (purely combinational).
//
// Ports:
//   window   in  3  {b[2i+1], b[2i], b[2i-1]}
//   sel_one  out 1  digit magnitude is 1 (A)
//   sel_two  out 1  digit magnitude is 2 (2A)
//   neg      out 1  digit is negative
// sel_one and sel_two are never both high; both low means a zero digit.
module booth_digit_enc
    import mult_pkg::*;
(
    input  logic [2:0] window,
    output logic       sel_one,
    output logic       sel_two,
    output logic       neg
);

    digit_t digit;

    always_comb begin
        digit   = booth_digit(window);
        sel_one = (digit == POS1) || (digit == NEG1);
        sel_two = (digit == POS2) || (digit == NEG2);
        neg     = (digit == NEG1) || (digit == NEG2);
    end

endmodule

// File: rtl/booth_seq_mult.sv
// Iterative radix-4 Booth multiplier for the RV32M execute stage.
// Handles MUL, MULH, MULHSU and MULHU on one datapath, retiring one Booth
// digit per cycle into a 2*XLEN+4 bit signed accumulator.
//
// Ports:
//   clk     in   1     rising-edge clock
//   rst     in   1     synchronous active-high reset
//   start   in   1     request, sampled only while idle
//   op      in   2     00 MUL, 01 MULH, 10 MULHSU, 11 MULHU (latched on accept)
//   oper_a  in   XLEN  multiplicand (rs1)
//   oper_b  in   XLEN  multiplier (rs2)
//   flush   in   1     abort the current operation
//   busy    out  1     high from the cycle after accept through the done cycle
//   done    out  1     one-cycle pulse, result valid
//   result  out  XLEN  MUL: low half of product, others: high half
//
// Handshake: start is accepted on a rising edge where the unit is idle,
// start=1 and flush=0. busy rises the cycle after accept and stays high up to
// and including the single done cycle. result holds between done pulses.
//
// XLEN must be even and at least 8.
//
// Build option: define BOOTH_EARLY_OUT_EN to finish as soon as the remaining
// multiplier bits are all equal (all remaining digits are zero). Without it
// every operation takes the same fixed latency.
module booth_seq_mult
    import mult_pkg::*;
#(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] oper_a,
    input  logic [XLEN-1:0] oper_b,
    input  logic            flush,
    output logic            busy,
    output logic            done,
    output logic [XLEN-1:0] result
);

    localparam int N_DIGITS = XLEN / 2 + 1;
    localparam int EXT_W    = XLEN + 2;
    localparam int MREG_W   = XLEN + 3;
    localparam int PP_W     = XLEN + 4;
    localparam int ACC_W    = 2 * XLEN + 4;
    localparam int CNT_W    = $clog2(N_DIGITS + 1);

    // Counter value of the final add-only CALC cycle.
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_DIGITS);

    // ------------------------------------------------------------------
    // State and datapath registers
    // ------------------------------------------------------------------
    state_t                    state_q;
    state_t                    state_d;
    logic [1:0]                op_q;
    logic signed [EXT_W-1:0]   ext_a_q;
    logic [MREG_W-1:0]         mreg_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic signed [ACC_W-1:0]   term_q;
    logic [CNT_W-1:0]          cnt_q;
    logic [XLEN-1:0]           result_q;

    // ------------------------------------------------------------------
    // Combinational helpers
    // ------------------------------------------------------------------
    logic                      accept;
    logic [EXT_W-1:0]          ext_a_in;
    logic [EXT_W-1:0]          ext_b_in;
    logic [CNT_W-1:0]          digit_idx;
    logic [MREG_W-1:0]         win_src;
    logic [2:0]                window;
    logic                      sel_one;
    logic                      sel_two;
    logic                      neg;
    logic signed [PP_W-1:0]    a_pp;
    logic signed [PP_W-1:0]    mag;
    logic signed [PP_W-1:0]    pp;
    logic signed [ACC_W-1:0]   term_next;
    logic                      early;
    logic                      calc_last;
    logic [XLEN-1:0]           result_sel;
    logic                      unused_acc_hi;

    assign accept    = (state_q == IDLE) && start && !flush;
    assign calc_last = (cnt_q == LAST_CNT);

    // Operand extension to XLEN+2 bits according to the requested op.
    always_comb begin
        ext_a_in = {{2{oper_a[XLEN-1] & a_is_signed(op)}}, oper_a};
        ext_b_in = {{2{oper_b[XLEN-1] & b_is_signed(op)}}, oper_b};
    end

    // The last CALC cycle has no digit of its own; park the window index at 0
    // there so the select stays inside the multiplier register.
    always_comb begin
        digit_idx = (cnt_q < LAST_CNT) ? cnt_q : '0;
        win_src   = mreg_q >> {digit_idx, 1'b0};
        window    = win_src[2:0];
    end

    booth_digit_enc u_enc (
        .window  (window),
        .sel_one (sel_one),
        .sel_two (sel_two),
        .neg     (neg)
    );

    // Partial product for the current digit, sign-extended and aligned.
    always_comb begin
        a_pp = PP_W'(ext_a_q);
        if (sel_two) begin
            mag = a_pp <<< 1;
        end else if (sel_one) begin
            mag = a_pp;
        end else begin
            mag = '0;
        end
        pp        = neg ? -mag : mag;
        term_next = ACC_W'(pp) <<< {digit_idx, 1'b0};
    end

`ifdef BOOTH_EARLY_OUT_EN
    // Bits from window position 2(cnt+1)-1 upward still feed future digits.
    // When they are all 0s or all 1s, every remaining digit encodes to zero.
    logic [CNT_W+1:0]          rest_sh;
    logic signed [MREG_W-1:0]  rest;

    always_comb begin
        rest_sh = {1'b0, cnt_q, 1'b0} + (CNT_W + 2)'(2);
        rest    = $signed(mreg_q) >>> rest_sh;
        early   = (cnt_q < LAST_CNT) && ((rest == '0) || (rest == '1));
    end
`else
    assign early = 1'b0;
`endif

    // Selected half of the product.
    always_comb begin
        if (op_q == OP_MUL) begin
            result_sel = acc_q[XLEN-1:0];
        end else begin
            result_sel = acc_q[2*XLEN-1:XLEN];
        end
    end

    // Guard bits above the product are only needed for intermediate sums.
    assign unused_acc_hi = ^acc_q[ACC_W-1:2*XLEN];

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d = CALC;
                end
            end
            CALC: begin
                if (flush) begin
                    state_d = IDLE;
                end else if (calc_last) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    // done is masked by flush so a squashed instruction never reports.
    always_comb begin
        busy   = (state_q != IDLE);
        done   = (state_q == DONE) && !flush;
        result = done ? result_sel : result_q;
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    // The Booth term is registered one cycle ahead of the accumulator add, so
    // the encode/shift/negate path and the wide adder sit in separate cycles.
    // CALC therefore runs digits 0..N_DIGITS-1 plus one add-only cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= OP_MUL;
            ext_a_q  <= '0;
            mreg_q   <= '0;
            acc_q    <= '0;
            term_q   <= '0;
            cnt_q    <= '0;
            result_q <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        op_q    <= op;
                        ext_a_q <= $signed(ext_a_in);
                        mreg_q  <= {ext_b_in, 1'b0};
                        acc_q   <= '0;
                        term_q  <= '0;
                        cnt_q   <= '0;
                    end
                end
                CALC: begin
                    acc_q <= acc_q + term_q;
                    if (calc_last) begin
                        term_q <= '0;
                    end else begin
                        term_q <= term_next;
                    end
                    // Early out skips straight to the add-only cycle.
                    if (early) begin
                        cnt_q <= LAST_CNT;
                    end else if (!calc_last) begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                DONE: begin
                    if (!flush) begin
                        result_q <= result_sel;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: doc/booth_seq_mult.md
Name: booth_seq_mult

Overview:
Iterative radix-4 Booth multiplier for the RV32M execute stage. It handles all four multiply ops (MUL, MULH, MULHSU, MULHU) with one shared datapath. It retires one Booth digit per cycle into a wide accumulator instead of producing all partial products at once. A start/busy/done handshake connects it to the pipeline stall logic, and flush supports squashed instructions.

Parameters:
XLEN, 32, operand/result width; must be even and >= 8
N_DIGITS, XLEN/2+1 (derived localparam, not overridable), Booth digits per operation after the 2-bit extension

Ports:
clk  in  1  rising-edge clock
rst  in  1  synchronous active-high reset
start  in  1  request; sampled only when busy=0
op  in  2  00 MUL, 01 MULH, 10 MULHSU, 11 MULHU; latched on accept
oper_a  in  XLEN  multiplicand (rs1)
oper_b  in  XLEN  multiplier (rs2)
flush  in  1  abort the current operation
busy  out  1  high from the cycle after accept until done inclusive
done  out  1  one-cycle pulse; result valid
result  out  XLEN  MUL: low half of product; MULH/MULHSU/MULHU: high half

Behaviour:
- Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, result=0; accumulator and counter cleared. Reset overrides start and flush, including mid-operation.
- Operand extension to XLEN+2 bits:
  - oper_a is sign-extended for MUL/MULH/MULHSU and zero-extended for MULHU.
  - oper_b is sign-extended for MUL/MULH and zero-extended for MULHSU/MULHU.
- Multiplier register: {ext_b, 1'b0}, XLEN+3 bits.
- Accumulator: 2*XLEN+4 bits, signed.
- Digit encode on the 3-bit window {b[2i+1], b[2i], b[2i-1]}:
  - 000/111 -> 0
  - 001/010 -> +A
  - 011 -> +2A
  - 100 -> -2A
  - 101/110 -> -A
- Partial product: XLEN+4 bits, sign-extended, shifted left by 2i.
- FSM:
  - IDLE: start=1 -> latch op and operands, clear accumulator, set counter=0, go to CALC.
  - CALC: add digit[counter] term, counter++. After digit N_DIGITS-1, go to DONE.
  - DONE: done=1 and result updated from accumulator bits (MUL: [XLEN-1:0]; others: [2*XLEN-1:XLEN]). Unconditionally go to IDLE.
- Latency: start sampled at edge T -> done high in the cycle after edge T+N_DIGITS+1 (T+18 for XLEN=32).
- Back-to-back: start may be asserted in the DONE cycle and is ignored. Earliest re-accept is the first IDLE cycle.
- start while busy=1: ignored, with no effect on operands or op.
- flush=1 in CALC or DONE: next state IDLE, done stays 0, result keeps its previous value. flush in IDLE: no effect, and start in the same cycle is dropped.
- result holds its last value until the next done. busy=0 in IDLE.
- Overflow wraps silently (mod 2^XLEN on the selected half). There is no divide-by-zero style special casing. Zero operands take the full latency unless the optional feature below is compiled in.

Optional Feature:
BOOTH_EARLY_OUT_EN.
- Defined: after each CALC add, if every unprocessed multiplier bit, from window bit 2(counter+1)-1 upward, is all 0s or all 1s, the FSM goes to DONE immediately. Remaining digits are all zero, so the product is unchanged. Minimum latency is done after edge T+2.
- Undefined: fixed latency N_DIGITS+2 for every operation.

Decomposition:
- Package mult_pkg holds:
  - the op encoding constants (OP_MUL, OP_MULH, OP_MULHSU, OP_MULHU)
  - the FSM state typedef (IDLE, CALC, DONE)
  - the Booth digit select typedef (ZERO, POS1, POS2, NEG1, NEG2)
- Sub-module booth_digit_enc: purely combinational. 3-bit window in; outputs select-one, select-two, negate. It is reused by the future parallel multiplier.

Test Plan:
- MUL 7 x 0xFFFFFFFD -> result 0xFFFFFFEB; done exactly at T+18, busy high T+1..T+18.
- MULH 0x80000000 x 0x80000000 -> 0x40000000; MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE; MULHSU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFF.
- Pulse start again during CALC with different operands -> first result unaffected (MUL 3x5 -> 0x0000000F), with a single done.
- flush at T+5 of MUL 9x9 -> no done, busy=0 at T+6, result retains its prior value. A new start at T+6 completes normally.
- rst at T+8 mid-operation -> busy=0, done=0, result=0 next cycle, and no done pulse afterwards.
- With BOOTH_EARLY_OUT_EN: MUL 5x1 -> result 5, done after edge T+2. With MUL 5x0x40000000, latency is strictly less than 18 and matches the fixed-latency result.
